// File: rtl/pwm_duty_ramp_pkg.sv
// Shared types and default widths for the PWM duty slew-rate limiter.
package pwm_duty_ramp_pkg;

  localparam int unsigned DW_DEFAULT   = 8;
  localparam int unsigned DIVW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_period_divider.sv
// Counts PWM period starts and flags every (ramp_div+1)-th one as a step event.
module pwm_period_divider
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned DIVW = DIVW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            period_start,
  input  logic [DIVW-1:0] ramp_div,
  output logic            step_evt
);

  localparam logic [DIVW-1:0] ONE = 1;

  logic [DIVW-1:0] div_cnt;

  assign step_evt = period_start && (div_cnt == ramp_div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
    end else if (period_start) begin
      div_cnt <= (div_cnt == ramp_div) ? '0 : div_cnt + ONE;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter stepping the PWM duty toward the SPI target at period boundaries.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned DIVW = DIVW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   target_duty,
  input  logic            ramp_en,
  input  logic [DW-1:0]   step_size,
  input  logic [DIVW-1:0] ramp_div,
  input  logic            period_start,
  output logic [DW-1:0]   duty_out,
  output logic            busy,
  output logic            done
);

  localparam logic [DW:0] ONE_X = 1;

  ramp_state_t state, state_n;
  logic [DW-1:0] duty_n;
  logic          done_n;
  logic          clr;
  logic          step_evt;
  logic [DW:0]   tgt_x, duty_x, eff_step, diff, amt, sum_up, sum_dn;

  pwm_period_divider #(
    .DIVW (DIVW)
  ) u_divider (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .period_start (period_start),
    .ramp_div     (ramp_div),
    .step_evt     (step_evt)
  );

  // Widened arithmetic; amt never exceeds the distance to target, so no wrap.
  always_comb begin
    tgt_x    = {1'b0, target_duty};
    duty_x   = {1'b0, duty_out};
    eff_step = (step_size == '0) ? ONE_X : {1'b0, step_size};
    diff     = (tgt_x >= duty_x) ? (tgt_x - duty_x) : (duty_x - tgt_x);
    amt      = (eff_step < diff) ? eff_step : diff;
    sum_up   = duty_x + amt;
    sum_dn   = duty_x - amt;
  end

  // A target change seen in a ramp state takes precedence over a step that cycle.
  always_comb begin
    state_n = state;
    duty_n  = duty_out;
    done_n  = 1'b0;
    clr     = 1'b0;
    if (!ramp_en) begin
      state_n = IDLE;
      duty_n  = target_duty;
      clr     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          clr = 1'b1;
          if (tgt_x > duty_x)      state_n = RAMP_UP;
          else if (tgt_x < duty_x) state_n = RAMP_DOWN;
        end
        RAMP_UP: begin
          if (tgt_x == duty_x) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (tgt_x < duty_x) begin
            state_n = RAMP_DOWN;
          end else if (step_evt) begin
            duty_n = sum_up[DW-1:0];
            if (amt == diff) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (tgt_x == duty_x) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (tgt_x > duty_x) begin
            state_n = RAMP_UP;
          end else if (step_evt) begin
            duty_n = sum_dn[DW-1:0];
            if (amt == diff) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      duty_out <= duty_n;
      done     <= done_n;
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed scenarios plus randomized run against a reference model.
module tb_pwm_duty_ramp;
  import pwm_duty_ramp_pkg::*;

  localparam int DW   = 8;
  localparam int DIVW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   target_duty;
  logic            ramp_en;
  logic [DW-1:0]   step_size;
  logic [DIVW-1:0] ramp_div;
  logic            period_start;
  logic [DW-1:0]   duty_out;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: duty value, direction (+1 up, -1 down, 0 settled), period count.
  int m_duty = 0;
  int m_dir  = 0;
  int m_cnt  = 0;
  int m_done = 0;

  pwm_duty_ramp #(
    .DW   (DW),
    .DIVW (DIVW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .target_duty  (target_duty),
    .ramp_en      (ramp_en),
    .step_size    (step_size),
    .ramp_div     (ramp_div),
    .period_start (period_start),
    .duty_out     (duty_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int t, d, eff, amt, side;
    @(posedge clk);
    t = int'(target_duty);
    if (rst) begin
      m_duty = 0; m_dir = 0; m_cnt = 0; m_done = 0;
    end else if (!ramp_en) begin
      m_duty = t; m_dir = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      side = (t > m_duty) ? 1 : ((t < m_duty) ? -1 : 0);
      if (m_dir == 0) begin
        m_cnt = 0;
        m_dir = side;
      end else if (side == 0) begin
        m_dir = 0; m_done = 1; m_cnt = 0;
      end else if (side != m_dir) begin
        m_dir = side;
        if (period_start) m_cnt = (m_cnt == int'(ramp_div)) ? 0 : (m_cnt + 1) % (1 << DIVW);
      end else if (period_start && m_cnt == int'(ramp_div)) begin
        m_cnt = 0;
        eff = (step_size == 0) ? 1 : int'(step_size);
        d = (t > m_duty) ? t - m_duty : m_duty - t;
        amt = (eff < d) ? eff : d;
        m_duty = m_duty + m_dir * amt;
        if (m_duty == t) begin
          m_dir = 0; m_done = 1;
        end
      end else if (period_start) begin
        m_cnt = (m_cnt + 1) % (1 << DIVW);
      end
    end
    #1;
  endtask

  task automatic settle_bypass(input logic [DW-1:0] val);
    ramp_en = 1'b0; target_duty = val; period_start = 1'b0;
    tick();
  endtask

  task automatic pulse();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ramp_en = 1'b1; target_duty = 8'h55; step_size = 8'h01;
    ramp_div = '0; period_start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: duty=%h busy=%b done=%b, required 00/0/0", duty_out, busy, done);
    end
  endtask

  task automatic test_bypass();
    int dones = 0;
    settle_bypass(8'h80);
    n_checks++;
    if (duty_out !== 8'h80 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_latency: duty=%h busy=%b, required 80/0", duty_out, busy);
    end
    if (done) dones++;
    target_duty = 8'h21;
    repeat (4) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (duty_out !== 8'h21 || dones != 0) begin
      n_fail++;
      $display("FAIL bypass_follow: duty=%h dones=%0d, required 21/0", duty_out, dones);
    end
  endtask

  task automatic test_ramp_up();
    int dones = 0;
    settle_bypass(8'h00);
    ramp_en = 1'b1; step_size = 8'h10; ramp_div = '0; target_duty = 8'h40;
    tick();
    n_checks++;
    if (duty_out !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_entry: duty=%h busy=%b, required 00/1", duty_out, busy);
    end
    for (int k = 1; k <= 4; k++) begin
      pulse();
      if (done) dones++;
      n_checks++;
      if (duty_out !== DW'(16 * k) || busy !== (k < 4) || done !== (k == 4)) begin
        n_fail++;
        $display("FAIL ramp_step%0d: duty=%h busy=%b done=%b, required %h/%b/%b",
                 k, duty_out, busy, done, 16 * k, k < 4, k == 4);
      end
      repeat (255) begin
        tick();
        if (done) dones++;
      end
    end
    n_checks++;
    if (dones != 1 || duty_out !== 8'h40) begin
      n_fail++;
      $display("FAIL ramp_done_once: dones=%0d duty=%h, required 1/40", dones, duty_out);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] up_exp [3];
    logic [DW-1:0] dn_exp [3];
    up_exp = '{8'h60, 8'hC0, 8'hFF};
    dn_exp = '{8'h9F, 8'h3F, 8'h00};
    settle_bypass(8'h00);
    ramp_en = 1'b1; step_size = 8'h60; ramp_div = '0; target_duty = 8'hFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse();
      n_checks++;
      if (duty_out !== up_exp[i]) begin
        n_fail++;
        $display("FAIL sat_up%0d: duty=%h, required %h", i, duty_out, up_exp[i]);
      end
      tick();
    end
    target_duty = 8'h00;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse();
      n_checks++;
      if (duty_out !== dn_exp[i]) begin
        n_fail++;
        $display("FAIL sat_down%0d: duty=%h, required %h", i, duty_out, dn_exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_divider_zero_step();
    settle_bypass(8'h10);
    ramp_en = 1'b1; step_size = 8'h00; ramp_div = 4'd2; target_duty = 8'h14;
    tick();
    for (int i = 1; i <= 9; i++) begin
      pulse();
      n_checks++;
      if (duty_out !== DW'(16 + i / 3)) begin
        n_fail++;
        $display("FAIL divider_pulse%0d: duty=%h, required %h", i, duty_out, 16 + i / 3);
      end
      tick(); tick();
    end
  endtask

  task automatic test_reversal();
    int dones = 0;
    int low = 255;
    settle_bypass(8'h20);
    ramp_en = 1'b1; step_size = 8'h10; ramp_div = '0; target_duty = 8'hA0;
    tick();
    repeat (3) begin
      pulse(); tick();
    end
    n_checks++;
    if (duty_out !== 8'h50) begin
      n_fail++;
      $display("FAIL reversal_pre: duty=%h, required 50", duty_out);
    end
    target_duty = 8'h30;
    tick();
    n_checks++;
    if (dut.state !== RAMP_DOWN || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reversal_state: state=%0d busy=%b, required %0d/1", dut.state, busy, RAMP_DOWN);
    end
    repeat (4) begin
      pulse();
      if (done) dones++;
      if (int'(duty_out) < low) low = int'(duty_out);
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (duty_out !== 8'h30 || low != 8'h30 || dones != 1) begin
      n_fail++;
      $display("FAIL reversal_end: duty=%h min=%h dones=%0d, required 30/30/1", duty_out, low, dones);
    end
  endtask

  task automatic test_interrupt();
    settle_bypass(8'h00);
    ramp_en = 1'b1; step_size = 8'h10; ramp_div = '0; target_duty = 8'h90;
    tick();
    pulse(); pulse();
    ramp_en = 1'b0;
    tick();
    n_checks++;
    if (duty_out !== 8'h90 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_en_drop: duty=%h done=%b busy=%b, required 90/0/0", duty_out, done, busy);
    end
    ramp_en = 1'b1; target_duty = 8'h10;
    tick();
    pulse();
    n_checks++;
    if (duty_out !== 8'h80 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL int_ramp_down: duty=%h busy=%b, required 80/1", duty_out, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ramp_reset: duty=%h busy=%b done=%b, required 00/0/0", duty_out, busy, done);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; period_start = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      ramp_en      = ($urandom_range(0, 99) >= 3);
      period_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) target_duty = DW'($urandom);
      if ($urandom_range(0, 29) == 0) step_size = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 80));
      if ($urandom_range(0, 49) == 0) ramp_div = DIVW'($urandom_range(0, 3));
      tick();
      n_checks++;
      if (duty_out !== DW'(m_duty) || busy !== (m_dir != 0) || done !== (m_done != 0)) begin
        n_fail++;
        $display("FAIL random_cycle%0d: duty=%h busy=%b done=%b, required %h/%b/%b",
                 i, duty_out, busy, done, m_duty, m_dir != 0, m_done != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ramp_up();
    test_saturation();
    test_divider_zero_step();
    test_reversal();
    test_interrupt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
